// File: rtl/note_scheduler.sv
// Song sequencer: walks the chart ROM, issues per-lane launch pulses when the
// song frame reaches each entry, and accumulates score/combo from hit/miss pulses.
module note_scheduler #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned CHART_AW   = 8,
    parameter int unsigned HIT_POINTS = 10,
    parameter logic [7:0]  START_KEY  = 8'h2C,
    parameter logic [7:0]  RESET_KEY  = 8'h01
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [7:0]           keycode_second,
    output logic [CHART_AW-1:0]  chart_addr,
    input  logic [15:0]          chart_data,
    input  logic [NUM_LANES-1:0] lane_busy,
    input  logic [NUM_LANES-1:0] hit,
    input  logic [NUM_LANES-1:0] miss,
    output logic [NUM_LANES-1:0] launch,
    output logic [15:0]          score,
    output logic [7:0]           combo,
    output logic [7:0]           max_combo,
    output logic [11:0]          song_frame,
    output logic                 song_done,
    output logic [1:0]           state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic                entry_end;
    logic [1:0]          entry_lane;
    logic [11:0]         entry_frame;
    logic                lane_ok;
    logic [3:0]          busy_pad;
    logic                start_pressed;
    logic                reset_pressed;
    logic                addr_last;

    logic [1:0]          state_next;
    logic                end_flag;
    logic                end_next;
    logic [CHART_AW-1:0] addr_next;
    logic [3:0]          launch_next;
    logic                song_clear;
    logic                advance;

    logic                active;
    logic [2:0]          hit_count;
    logic [31:0]         score_sum;
    logic [31:0]         combo_sum;
    logic [15:0]         score_next;
    logic [7:0]          combo_next;
    logic [7:0]          max_next;

    always_comb begin
        entry_end     = chart_data[15];
        entry_lane    = chart_data[14:13];
        entry_frame   = chart_data[11:0];
        lane_ok       = (32'(entry_lane) < NUM_LANES);
        start_pressed = (keycode == START_KEY) || (keycode_second == START_KEY);
        reset_pressed = (keycode == RESET_KEY) || (keycode_second == RESET_KEY);
        addr_last     = (chart_addr == '1);
    end

    // Lane field is 2 bits; pad busy so narrower lane counts index safely.
    always_comb begin
        busy_pad                = '0;
        busy_pad[NUM_LANES-1:0] = lane_busy;
    end

    always_comb begin
        state_next  = state;
        end_next    = end_flag;
        addr_next   = chart_addr;
        launch_next = '0;
        song_clear  = 1'b0;
        advance     = 1'b0;

        case (state)
            IDLE: begin
                if (start_pressed) begin
                    state_next = FETCH;
                    addr_next  = '0;
                    end_next   = 1'b0;
                    song_clear = 1'b1;
                end
            end
            FETCH: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (end_flag) begin
                    if (lane_busy == '0) begin
                        state_next = DONE;
                    end
                end else if (entry_end) begin
                    end_next = 1'b1;
                end else if (song_frame >= entry_frame) begin
                    if (!lane_ok) begin
                        advance = 1'b1;
                    end else if (!busy_pad[entry_lane]) begin
                        launch_next[entry_lane] = 1'b1;
                        advance                 = 1'b1;
                    end
                end

                // Running off the end of the ROM acts like an end marker.
                if (advance) begin
                    if (addr_last) begin
                        end_next = 1'b1;
                    end else begin
                        addr_next  = chart_addr + 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            default: begin
                if (reset_pressed) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        active    = (state == FETCH) || (state == CHECK);
        hit_count = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            hit_count = hit_count + 3'(hit[i]);
        end

        score_sum  = 32'(score) + 32'(hit_count) * HIT_POINTS;
        score_next = (score_sum > 32'hFFFF) ? 16'hFFFF : score_sum[15:0];

        combo_sum = 32'(combo) + 32'(hit_count);
        if (miss != '0) begin
            combo_next = '0;
        end else if (combo_sum > 32'd255) begin
            combo_next = 8'hFF;
        end else begin
            combo_next = combo_sum[7:0];
        end

        max_next = (combo_next > max_combo) ? combo_next : max_combo;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            end_flag   <= 1'b0;
            chart_addr <= '0;
            launch     <= '0;
            song_done  <= 1'b0;
        end else begin
            state      <= state_next;
            end_flag   <= end_next;
            chart_addr <= addr_next;
            launch     <= launch_next[NUM_LANES-1:0];
            song_done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
            song_frame <= '0;
        end else if (song_clear) begin
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
            song_frame <= '0;
        end else if (active) begin
            score     <= score_next;
            combo     <= combo_next;
            max_combo <= max_next;
            if (song_frame != '1) begin
                song_frame <= song_frame + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a synchronous chart ROM model.
module tb_note_scheduler;

    logic        frame_clk;
    logic        Reset;
    logic [7:0]  keycode;
    logic [7:0]  keycode_second;
    logic [7:0]  chart_addr;
    logic [15:0] chart_data;
    logic [3:0]  lane_busy;
    logic [3:0]  hit;
    logic [3:0]  miss;
    logic [3:0]  launch;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [11:0] song_frame;
    logic        song_done;
    logic [1:0]  state;

    logic [15:0] rom [256];

    int vectors;
    int miscompares;
    int launch_seen;
    int multi_launch;
    int cycles;

    note_scheduler #(
        .NUM_LANES (4),
        .CHART_AW  (8),
        .HIT_POINTS(10),
        .START_KEY (8'h2C),
        .RESET_KEY (8'h01)
    ) dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycode       (keycode),
        .keycode_second(keycode_second),
        .chart_addr    (chart_addr),
        .chart_data    (chart_data),
        .lane_busy     (lane_busy),
        .hit           (hit),
        .miss          (miss),
        .launch        (launch),
        .score         (score),
        .combo         (combo),
        .max_combo     (max_combo),
        .song_frame    (song_frame),
        .song_done     (song_done),
        .state         (state)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk) chart_data <= rom[chart_addr];

    function automatic logic [15:0] ent(input logic e, input logic [1:0] lane, input logic [11:0] fr);
        return {e, lane, 1'b0, fr};
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        Reset          = 1'b1;
        keycode        = '0;
        keycode_second = '0;
        lane_busy      = '0;
        hit            = '0;
        miss           = '0;
        chart_data     = '0;
        for (int i = 0; i < 256; i++) rom[i] = ent(1'b1, 2'd0, 12'd0);
        rom[0] = ent(1'b0, 2'd0, 12'd5);
        rom[1] = ent(1'b0, 2'd2, 12'd5);
        rom[2] = ent(1'b1, 2'd0, 12'd0);

        tick();
        tick();
        Reset = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_combo", 32'(combo), 32'd0);
        chk("rst_frame", 32'(song_frame), 32'd0);
        chk("rst_launch", 32'(launch), 32'd0);
        chk("rst_addr", 32'(chart_addr), 32'd0);
        chk("rst_done", 32'(song_done), 32'd0);

        // Song A: two launches at frame 5 with scoring while waiting.
        keycode = 8'h2C;
        tick();
        keycode = 8'h00;
        chk("a_fetch", 32'(state), 32'd1);
        chk("a_frame0", 32'(song_frame), 32'd0);
        tick();
        chk("a_check", 32'(state), 32'd2);
        hit = 4'b0111;
        tick();
        chk("a_score30", 32'(score), 32'd30);
        chk("a_combo3", 32'(combo), 32'd3);
        hit = 4'b0101;
        tick();
        chk("a_score50", 32'(score), 32'd50);
        chk("a_combo5", 32'(combo), 32'd5);
        chk("a_max5", 32'(max_combo), 32'd5);
        hit  = 4'b0001;
        miss = 4'b0010;
        tick();
        hit  = 4'b0000;
        miss = 4'b0000;
        chk("a_score60", 32'(score), 32'd60);
        chk("a_combo0", 32'(combo), 32'd0);
        chk("a_max_keep", 32'(max_combo), 32'd5);
        tick();
        chk("a_nolaunch_f5", 32'(launch), 32'd0);
        chk("a_frame5", 32'(song_frame), 32'd5);
        tick();
        chk("a_launch0", 32'(launch), 32'b0001);
        chk("a_addr1", 32'(chart_addr), 32'd1);
        tick();
        chk("a_gap", 32'(launch), 32'd0);
        tick();
        chk("a_launch2", 32'(launch), 32'b0100);
        chk("a_frame8", 32'(song_frame), 32'd8);
        lane_busy = 4'b0100;
        tick();
        chk("a_launch_clr", 32'(launch), 32'd0);
        tick();
        tick();
        chk("a_drain_hold", 32'(state), 32'd2);
        lane_busy = 4'b0000;
        tick();
        chk("a_done_state", 32'(state), 32'd3);
        chk("a_done_flag", 32'(song_done), 32'd1);
        chk("a_frame12", 32'(song_frame), 32'd12);
        tick();
        chk("a_frame_frozen", 32'(song_frame), 32'd12);

        keycode = 8'h2C;
        tick();
        keycode = 8'h00;
        chk("done_start_ign", 32'(state), 32'd3);
        keycode_second = 8'h01;
        tick();
        keycode_second = 8'h00;
        chk("done_to_idle", 32'(state), 32'd0);
        chk("idle_score_keep", 32'(score), 32'd60);
        chk("idle_done_low", 32'(song_done), 32'd0);
        hit = 4'b1111;
        tick();
        hit = 4'b0000;
        chk("idle_hit_ign", 32'(score), 32'd60);

        // Song B: due entry on a busy lane, then saturation while draining.
        rom[0] = ent(1'b0, 2'd1, 12'd3);
        rom[1] = ent(1'b1, 2'd0, 12'd0);
        keycode = 8'h2C;
        tick();
        keycode = 8'h00;
        chk("b_score_clr", 32'(score), 32'd0);
        chk("b_max_clr", 32'(max_combo), 32'd0);
        chk("b_frame_clr", 32'(song_frame), 32'd0);
        tick();
        lane_busy   = 4'b0010;
        launch_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (launch != '0) launch_seen++;
        end
        chk("b_busy_nolaunch", 32'(launch_seen), 32'd0);
        chk("b_frame11", 32'(song_frame), 32'd11);
        lane_busy = 4'b1000;
        tick();
        chk("b_launch1", 32'(launch), 32'b0010);
        chk("b_frame12", 32'(song_frame), 32'd12);
        tick();
        tick();
        tick();
        chk("b_draining", 32'(state), 32'd2);
        hit = 4'b0001;
        for (int i = 0; i < 300; i++) tick();
        chk("b_combo_sat", 32'(combo), 32'd255);
        chk("b_max_sat", 32'(max_combo), 32'd255);
        chk("b_score3000", 32'(score), 32'd3000);
        for (int i = 0; i < 6253; i++) tick();
        chk("b_score65530", 32'(score), 32'd65530);
        tick();
        chk("b_score_sat", 32'(score), 32'hFFFF);
        tick();
        chk("b_score_hold", 32'(score), 32'hFFFF);
        chk("b_frame_sat", 32'(song_frame), 32'd4095);
        hit  = 4'b0000;
        miss = 4'b0001;
        tick();
        miss = 4'b0000;
        chk("b_miss_combo", 32'(combo), 32'd0);
        chk("b_miss_max", 32'(max_combo), 32'd255);
        lane_busy = 4'b0000;
        tick();
        chk("b_done", 32'(state), 32'd3);
        keycode_second = 8'h01;
        tick();
        keycode_second = 8'h00;
        chk("b_idle_score", 32'(score), 32'hFFFF);

        // Address wrap with no end marker: 256 launches then done.
        for (int i = 0; i < 256; i++) rom[i] = ent(1'b0, 2'd3, 12'd0);
        keycode = 8'h2C;
        tick();
        keycode      = 8'h00;
        launch_seen  = 0;
        multi_launch = 0;
        cycles       = 0;
        while (state != 2'd3 && cycles < 2000) begin
            tick();
            cycles++;
            if (launch == 4'b1000) launch_seen++;
            else if (launch != 4'b0000) multi_launch++;
        end
        chk("wrap_done", 32'(state), 32'd3);
        chk("wrap_launches", 32'(launch_seen), 32'd256);
        chk("wrap_bad_launch", 32'(multi_launch), 32'd0);
        keycode = 8'h01;
        tick();
        keycode = 8'h00;

        // Asynchronous reset in the middle of a song.
        rom[0] = ent(1'b0, 2'd0, 12'd100);
        rom[1] = ent(1'b1, 2'd0, 12'd0);
        keycode = 8'h2C;
        tick();
        keycode = 8'h00;
        tick();
        hit = 4'b0111;
        tick();
        hit = 4'b0000;
        chk("m_score30", 32'(score), 32'd30);
        chk("m_state", 32'(state), 32'd2);
        Reset = 1'b1;
        #1;
        chk("m_rst_state", 32'(state), 32'd0);
        chk("m_rst_score", 32'(score), 32'd0);
        chk("m_rst_combo", 32'(combo), 32'd0);
        chk("m_rst_max", 32'(max_combo), 32'd0);
        chk("m_rst_frame", 32'(song_frame), 32'd0);
        chk("m_rst_addr", 32'(chart_addr), 32'd0);
        keycode = 8'h2C;
        tick();
        chk("m_rst_wins", 32'(state), 32'd0);
        Reset   = 1'b0;
        keycode = 8'h00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
Sequences the lane droppers for one song. Walks a chart ROM of (launch frame, lane) entries and issues one-frame launch pulses to the matching dropper lane when the song frame counter reaches each entry's frame. Aggregates per-lane hit/miss pulses into score, combo and max-combo for the HUD. Sits between the keyboard keycode path, the chart ROM, the dropper array and the score display.

Parameters:
NUM_LANES, 4, number of dropper lanes (lane field is 2 bits; NUM_LANES must be ≤4)
CHART_AW, 8, chart ROM address width
HIT_POINTS, 10, points added per hit pulse
START_KEY, 8'h2C, keycode that starts a song
RESET_KEY, 8'h01, keycode that returns from DONE to IDLE

Ports:
frame_clk  in  1  frame clock; all state advances on its rising edge
Reset  in  1  asynchronous, active-high reset
keycode  in  8  primary keycode
keycode_second  in  8  secondary keycode
chart_addr  out  CHART_AW  chart ROM address, registered
chart_data  in  16  ROM word, valid one frame_clk after chart_addr changes; [15]=end marker, [14:13]=lane, [12]=unused, [11:0]=launch frame
lane_busy  in  NUM_LANES  dropper lane currently has an arrow in flight
hit  in  NUM_LANES  one-cycle hit pulse per lane
miss  in  NUM_LANES  one-cycle miss pulse per lane
launch  out  NUM_LANES  one-cycle launch pulse, at most one bit set per cycle
score  out  16  accumulated score
combo  out  8  current consecutive-hit count
max_combo  out  8  highest combo this song
song_frame  out  12  frame counter
song_done  out  1  high while in DONE
state  out  2  IDLE=0, FETCH=1, CHECK=2, DONE=3 (DRAIN encoded as CHECK with end flag; see below)

Behaviour:
- Reset (async, any state, mid-song included): state IDLE, chart_addr 0, launch 0, score 0, combo 0, max_combo 0, song_frame 0, song_done 0, internal end flag 0.
- IDLE: outputs hold last song's score/combo/max_combo. keycode==START_KEY or keycode_second==START_KEY -> FETCH next cycle; on that transition clear score, combo, max_combo, song_frame, chart_addr, end flag.
- FETCH: one-cycle ROM wait; -> CHECK.
- CHECK (end flag 0): if chart_data[15] -> set end flag (drain). Else if song_frame >= chart_data[11:0]: if lane_busy[lane]==0 -> launch[lane]=1 this cycle, chart_addr+1, -> FETCH; if busy -> stall in CHECK, no launch, retry next cycle. Else stay CHECK.
- Lane field ≥ NUM_LANES: entry skipped (chart_addr+1, -> FETCH, no launch).
- chart_addr wrap from all-ones to 0 without end marker: treated as end marker (set end flag).
- CHECK (end flag 1, drain): when lane_busy==0 -> DONE.
- DONE: song_done=1; song_frame frozen. RESET_KEY on either keycode -> IDLE. START_KEY in DONE ignored.
- song_frame: +1 each cycle in FETCH and CHECK, saturates at 4095; held in IDLE/DONE.
- launch is a registered output: asserted exactly one frame_clk cycle per accepted entry; never two bits set.
- Scoring (active in FETCH/CHECK only; hit/miss ignored in IDLE/DONE): n = popcount(hit). score += n*HIT_POINTS, saturating at 16'hFFFF. If any miss bit set: combo=0 (miss wins over simultaneous hits; points still added). Else combo += n, saturating at 255. max_combo = max(max_combo, new combo), updated same cycle.
- Same-cycle start key and Reset: Reset wins.

Test Plan:
- Reset mid-song (CHECK, score 30) -> all outputs 0 and state IDLE asynchronously, before next edge.
- Chart {frame 5 lane 0, frame 5 lane 2, end}; press 8'h2C -> launch[0] pulses once at song_frame≥5, launch[2] two cycles later, never same cycle; DONE once lane_busy=0.
- lane_busy[1]=1 for 10 cycles with due entry on lane 1 -> no launch while busy; launch[1] one cycle after busy drops; song_frame keeps counting.
- hit=4'b0101 in one cycle from combo 3 -> score +20, combo 5, max_combo 5; next cycle hit=4'b0001, miss=4'b0010 -> score +10, combo 0, max_combo 5.
- 6554 single hits -> score saturates 16'hFFFF; 300 consecutive hits -> combo 255.
- DONE: keycode 8'h2C ignored; keycode_second 8'h01 -> IDLE with score preserved; subsequent 8'h2C clears score to 0.
